// File: rtl/int_ctrl_if.sv
// Processor-side bus of the interrupt controller: request/acknowledge handshake
// plus the enable-register write port.
interface int_ctrl_if #(
  parameter int W       = 16,
  parameter int NUM_SRC = 4
);
  // Handshake: interrupt is the "valid" and int_ack the "ready". While interrupt=1,
  // int_vector is held stable until a cycle with int_ack=1. That transfer starts
  // service (busy=1), which ends on the first cycle with int_done=1. Outside those
  // windows, int_ack and int_done have no effect.
  logic               interrupt;
  logic [W-1:0]       int_vector;
  logic               busy;
  logic               int_ack;
  logic               int_done;
  logic               en_we;
  logic [NUM_SRC-1:0] en_wdata;

  modport master (
    output interrupt,
    output int_vector,
    output busy,
    input  int_ack,
    input  int_done,
    input  en_we,
    input  en_wdata
  );

  modport slave (
    input  interrupt,
    input  int_vector,
    input  busy,
    output int_ack,
    output int_done,
    output en_we,
    output en_wdata
  );
endinterface

// File: rtl/int_ctrl.sv
// Edge-triggered, fixed-priority interrupt controller with a maskable pending
// register and a non-nesting IDLE/REQ/SERVICE request FSM.
module int_ctrl #(
  parameter int             W        = 16,
  parameter int             NUM_SRC  = 4,
  parameter logic [W-1:0]   VEC_BASE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  int_ctrl_if.master         bus,
  output logic [NUM_SRC-1:0] pending,
  output logic [1:0]         state_dbg,
  output logic [NUM_SRC-1:0] enable_dbg
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_nx;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] irq_edge;
  logic [NUM_SRC-1:0] pending_q, enable_q;
  logic [NUM_SRC-1:0] eligible, pend_clr;
  logic [IW-1:0]      idx_q, idx_nx, sel_idx;
  logic               sel_found;
  logic               interrupt_q, interrupt_nx;
  logic               busy_q, busy_nx;
  logic [W-1:0]       vector_q, vector_nx;

  // Synchronizer plus history flop; s3 clears in reset so a line that is
  // already high at release is seen as a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign irq_edge = s2_q & ~s3_q;

  // Pending ignores the mask; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      enable_q  <= '1;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | irq_edge;
      if (bus.en_we) enable_q <= bus.en_wdata;
    end
  end

  assign eligible = pending_q & enable_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
      vector_q    <= '0;
    end else begin
      state_q     <= state_nx;
      idx_q       <= idx_nx;
      interrupt_q <= interrupt_nx;
      busy_q      <= busy_nx;
      vector_q    <= vector_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    idx_nx       = idx_q;
    interrupt_nx = interrupt_q;
    busy_nx      = busy_q;
    vector_nx    = vector_q;
    pend_clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_nx     = ST_REQ;
          idx_nx       = sel_idx;
          vector_nx    = VEC_BASE + (W'(sel_idx) << 1);
          interrupt_nx = 1'b1;
        end
      end
      ST_REQ: begin
        // int_done is deliberately not looked at here, even alongside int_ack.
        if (bus.int_ack) begin
          state_nx     = ST_SERVICE;
          interrupt_nx = 1'b0;
          busy_nx      = 1'b1;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_q == IW'(i)) pend_clr[i] = 1'b1;
          end
        end
      end
      ST_SERVICE: begin
        if (bus.int_done) begin
          state_nx = ST_IDLE;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx     = ST_IDLE;
        interrupt_nx = 1'b0;
        busy_nx      = 1'b0;
      end
    endcase
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.int_vector = vector_q;
  assign bus.busy       = busy_q;
  assign pending        = pending_q;
  assign state_dbg      = state_q;
  assign enable_dbg     = enable_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (W=16, NUM_SRC=4, VEC_BASE=0) with hand-computed
// expectations checked by immediate assertions.
module tb_int_ctrl;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic       clk;
  logic       rst;
  logic [3:0] irq;
  logic [3:0] pending;
  logic [1:0] state_dbg;
  logic [3:0] enable_dbg;
  int         tests;
  int         fails;

  int_ctrl_if #(.W(16), .NUM_SRC(4)) ifc ();

  int_ctrl #(.W(16), .NUM_SRC(4), .VEC_BASE(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq),
    .bus        (ifc),
    .pending    (pending),
    .state_dbg  (state_dbg),
    .enable_dbg (enable_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    ifc.int_ack = 1'b1;
    tick();
    ifc.int_ack = 1'b0;
  endtask

  task automatic done_pulse();
    ifc.int_done = 1'b1;
    tick();
    ifc.int_done = 1'b0;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst          = 1'b0;
    irq          = '0;
    ifc.int_ack  = 1'b0;
    ifc.int_done = 1'b0;
    ifc.en_we    = 1'b0;
    ifc.en_wdata = '0;

    // Reset state
    #12;
    check("rst_interrupt", 32'(ifc.interrupt), 32'd0);
    check("rst_vector", 32'(ifc.int_vector), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_enable", 32'(enable_dbg), 32'hf);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b1;
    tick(2);

    // Single source latency: irq[2] rises before E0
    irq[2] = 1'b1;
    tick(2);
    check("lat_pending_e1", 32'(pending), 32'h0);
    tick();
    check("lat_pending_e2", 32'(pending), 32'h4);
    check("lat_int_e2", 32'(ifc.interrupt), 32'd0);
    tick();
    check("lat_int_e3", 32'(ifc.interrupt), 32'd1);
    check("lat_vec_e3", 32'(ifc.int_vector), 32'h0004);
    check("lat_state_e3", 32'(state_dbg), 32'(ST_REQ));
    ack_pulse();
    check("lat_busy", 32'(ifc.busy), 32'd1);
    check("lat_int_off", 32'(ifc.interrupt), 32'd0);
    check("lat_pend_clr", 32'(pending), 32'h0);
    irq[2] = 1'b0;
    done_pulse();
    check("lat_busy_off", 32'(ifc.busy), 32'd0);
    check("lat_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    tick(3);
    check("lat_vec_retained", 32'(ifc.int_vector), 32'h0004);
    check("lat_no_rereq", 32'(ifc.interrupt), 32'd0);

    // Priority: irq[3] and irq[1] together
    irq[3] = 1'b1;
    irq[1] = 1'b1;
    tick(3);
    check("pri_pending", 32'(pending), 32'ha);
    tick();
    check("pri_int1", 32'(ifc.interrupt), 32'd1);
    check("pri_vec1", 32'(ifc.int_vector), 32'h0002);
    ack_pulse();
    check("pri_pending_after_ack", 32'(pending), 32'h8);
    done_pulse();
    check("pri_gap_int", 32'(ifc.interrupt), 32'd0);
    tick();
    check("pri_int2", 32'(ifc.interrupt), 32'd1);
    check("pri_vec2", 32'(ifc.int_vector), 32'h0006);
    ack_pulse();
    check("pri_pending_end", 32'(pending), 32'h0);
    done_pulse();
    irq = '0;
    tick(3);

    // Masking
    ifc.en_we    = 1'b1;
    ifc.en_wdata = 4'b1110;
    tick();
    ifc.en_we = 1'b0;
    check("mask_enable", 32'(enable_dbg), 32'he);
    irq[0] = 1'b1;
    tick(3);
    check("mask_pending", 32'(pending), 32'h1);
    tick(3);
    check("mask_int_held_off", 32'(ifc.interrupt), 32'd0);
    ifc.en_we    = 1'b1;
    ifc.en_wdata = 4'b1111;
    tick();
    ifc.en_we = 1'b0;
    check("unmask_int_next", 32'(ifc.interrupt), 32'd0);
    tick();
    check("unmask_int", 32'(ifc.interrupt), 32'd1);
    check("unmask_vec", 32'(ifc.int_vector), 32'h0000);

    // Handshake: stall in REQ, stray int_done, then ack+done together
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hs_hold_int", 32'(ifc.interrupt), 32'd1);
      check("hs_hold_vec", 32'(ifc.int_vector), 32'h0000);
    end
    done_pulse();
    check("hs_done_ignored", 32'(state_dbg), 32'(ST_REQ));
    check("hs_done_int", 32'(ifc.interrupt), 32'd1);
    ifc.int_ack  = 1'b1;
    ifc.int_done = 1'b1;
    tick();
    ifc.int_ack  = 1'b0;
    ifc.int_done = 1'b0;
    check("hs_ack_state", 32'(state_dbg), 32'(ST_SERVICE));
    check("hs_ack_busy", 32'(ifc.busy), 32'd1);
    check("hs_ack_int", 32'(ifc.interrupt), 32'd0);
    irq[0] = 1'b0;
    done_pulse();
    tick(3);

    // Set/clear collision on the latched source
    irq[1] = 1'b1;
    tick(4);
    check("col_vec", 32'(ifc.int_vector), 32'h0002);
    irq[1] = 1'b0;
    tick(3);
    irq[1] = 1'b1;
    tick(2);
    ifc.int_ack = 1'b1;
    tick();
    ifc.int_ack = 1'b0;
    check("col_pending_kept", 32'(pending), 32'h2);
    check("col_busy", 32'(ifc.busy), 32'd1);
    done_pulse();
    tick();
    check("col_reserve_int", 32'(ifc.interrupt), 32'd1);
    check("col_reserve_vec", 32'(ifc.int_vector), 32'h0002);
    ack_pulse();
    check("col_pending_end", 32'(pending), 32'h0);
    done_pulse();
    irq[1] = 1'b0;
    tick(3);

    // Reset mid-SERVICE
    irq[3] = 1'b1;
    tick(4);
    check("rs_vec", 32'(ifc.int_vector), 32'h0006);
    ack_pulse();
    ifc.en_we    = 1'b1;
    ifc.en_wdata = 4'b0011;
    tick();
    ifc.en_we = 1'b0;
    check("rs_enable_written", 32'(enable_dbg), 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("rs_busy", 32'(ifc.busy), 32'd0);
    check("rs_int", 32'(ifc.interrupt), 32'd0);
    check("rs_vec0", 32'(ifc.int_vector), 32'h0);
    check("rs_enable", 32'(enable_dbg), 32'hf);
    check("rs_state", 32'(state_dbg), 32'(ST_IDLE));
    irq[3] = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(6);
    check("rs_no_rereq", 32'(ifc.interrupt), 32'd0);
    check("rs_no_pending", 32'(pending), 32'h0);

    // Line already high at reset release
    rst    = 1'b0;
    irq[2] = 1'b1;
    tick();
    rst = 1'b1;
    tick(4);
    check("rel_int", 32'(ifc.interrupt), 32'd1);
    check("rel_vec", 32'(ifc.int_vector), 32'h0004);
    ack_pulse();
    done_pulse();
    check("rel_idle", 32'(state_dbg), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
